config_stream_writer: RTL and testbench

Configuration-side driver for the cluster loaders: accepts a byte stream of configuration records over a valid/ready handshake and replays each record onto the loader bus (ADDRESS, DATA, SELECT_LEVEL) with fixed setup/strobe/hold sequencing. It sits between the bitstream source and the `conf_ck`/`address`/`cluster_data`/`selector` inputs of one or more clusters. It also reports record count, completion and format errors.

---
 rtl/cfg_writer_pkg.sv | 20 ++
 rtl/config_stream_writer.sv | 119 +++++++++++
 tb/tb_config_stream_writer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_writer_pkg.sv
// Shared definitions for the configuration stream writer: sequencer states,
// record header bit positions and the record counter width.
package cfg_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_DAT    = 3'd2,
        ST_SETUP  = 3'd3,
        ST_STROBE = 3'd4,
        ST_HOLD   = 3'd5,
        ST_FIN    = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    localparam int LAST_BIT    = 7;
    localparam int RSVD_BIT    = 6;
    localparam int REC_COUNT_W = 16;

endpackage

// File: rtl/config_stream_writer.sv
// Replays two-byte configuration records from a valid/ready byte stream onto the
// loader bus with setup / one-cycle strobe / hold sequencing.
module config_stream_writer
    import cfg_writer_pkg::*;
#(
    parameter int ADDRESS_SIZE = 6,
    parameter int DATA_SIZE    = 8,
    parameter int MAX_ADDRESS  = 63,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    START,
    input  logic [DATA_SIZE-1:0]    IN_DATA,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [ADDRESS_SIZE-1:0] ADDRESS,
    output logic [DATA_SIZE-1:0]    DATA,
    output logic                    SELECT_LEVEL,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERROR,
    output logic [REC_COUNT_W-1:0]  RECORD_COUNT
);

    state_t                  state_reg;
    logic [3:0]              hold_cnt_reg;
    logic                    last_reg;
    logic [ADDRESS_SIZE-1:0] hdr_addr_reg;
    logic                    hdr_bad;

    // A header is rejected when the reserved bit is set or the address is out of range.
    assign hdr_bad = IN_DATA[RSVD_BIT] ||
                     (32'(IN_DATA[ADDRESS_SIZE-1:0]) > MAX_ADDRESS);

    // Every output is a register updated alongside the state transition, so
    // IN_READY never depends combinationally on IN_VALID.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= '0;
            last_reg     <= 1'b0;
            hdr_addr_reg <= '0;
            IN_READY     <= 1'b0;
            ADDRESS      <= '0;
            DATA         <= '0;
            SELECT_LEVEL <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            ERROR        <= 1'b0;
            RECORD_COUNT <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_FIN, ST_ERR: begin
                    if (START) begin
                        state_reg    <= ST_HDR;
                        IN_READY     <= 1'b1;
                        BUSY         <= 1'b1;
                        DONE         <= 1'b0;
                        ERROR        <= 1'b0;
                        RECORD_COUNT <= '0;
                    end
                end
                ST_HDR: begin
                    if (IN_VALID && IN_READY) begin
                        if (hdr_bad) begin
                            state_reg <= ST_ERR;
                            IN_READY  <= 1'b0;
                            BUSY      <= 1'b0;
                            ERROR     <= 1'b1;
                        end else begin
                            state_reg    <= ST_DAT;
                            hdr_addr_reg <= IN_DATA[ADDRESS_SIZE-1:0];
                            last_reg     <= IN_DATA[LAST_BIT];
                        end
                    end
                end
                ST_DAT: begin
                    if (IN_VALID && IN_READY) begin
                        state_reg <= ST_SETUP;
                        IN_READY  <= 1'b0;
                        ADDRESS   <= hdr_addr_reg;
                        DATA      <= IN_DATA;
                    end
                end
                ST_SETUP: begin
                    state_reg    <= ST_STROBE;
                    SELECT_LEVEL <= 1'b1;
                    if (RECORD_COUNT != '1) begin
                        RECORD_COUNT <= RECORD_COUNT + 1'b1;
                    end
                end
                ST_STROBE: begin
                    state_reg    <= ST_HOLD;
                    SELECT_LEVEL <= 1'b0;
                    hold_cnt_reg <= 4'(HOLD_CYCLES - 1);
                end
                ST_HOLD: begin
                    if (hold_cnt_reg == 4'd0) begin
                        if (last_reg) begin
                            state_reg <= ST_FIN;
                            BUSY      <= 1'b0;
                            DONE      <= 1'b1;
                        end else begin
                            state_reg <= ST_HDR;
                            IN_READY  <= 1'b1;
                        end
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_stream_writer.sv
// Directed bench for config_stream_writer: instance a uses the default
// parameters, instance b uses MAX_ADDRESS=39 and HOLD_CYCLES=3.
module tb_config_stream_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;

    logic        a_ready, a_sel, a_busy, a_done, a_error;
    logic [5:0]  a_addr;
    logic [7:0]  a_data;
    logic [15:0] a_count;

    logic        b_ready, b_sel, b_busy, b_done, b_error;
    logic [5:0]  b_addr;
    logic [7:0]  b_data;
    logic [15:0] b_count;

    int vectors = 0;
    int miscompares = 0;

    int cyc = 0;
    int strobe_n = 0;
    int strobe_at [0:15];

    always #5 clk = ~clk;

    config_stream_writer #(
        .ADDRESS_SIZE(6), .DATA_SIZE(8), .MAX_ADDRESS(63), .HOLD_CYCLES(1)
    ) dut_a (
        .CLK(clk), .RESET(reset), .START(start), .IN_DATA(in_data),
        .IN_VALID(in_valid), .IN_READY(a_ready), .ADDRESS(a_addr),
        .DATA(a_data), .SELECT_LEVEL(a_sel), .BUSY(a_busy), .DONE(a_done),
        .ERROR(a_error), .RECORD_COUNT(a_count)
    );

    config_stream_writer #(
        .ADDRESS_SIZE(6), .DATA_SIZE(8), .MAX_ADDRESS(39), .HOLD_CYCLES(3)
    ) dut_b (
        .CLK(clk), .RESET(reset), .START(start), .IN_DATA(in_data),
        .IN_VALID(in_valid), .IN_READY(b_ready), .ADDRESS(b_addr),
        .DATA(b_data), .SELECT_LEVEL(b_sel), .BUSY(b_busy), .DONE(b_done),
        .ERROR(b_error), .RECORD_COUNT(b_count)
    );

    // Strobe log for instance a, sampled mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (a_sel) begin
            strobe_at[strobe_n % 16] = cyc;
            strobe_n = strobe_n + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-16s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a byte and hold it until the chosen instance accepts it.
    task automatic send(input logic [7:0] b, input bit on_b);
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!(on_b ? b_ready : a_ready) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int base;
        reset = 1'b1; start = 1'b1; in_data = 8'h00; in_valid = 1'b0;
        tick();
        tick();
        // START coincident with RESET must not begin a session
        chk("rst_ready", 32'(a_ready), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_outs", {a_addr, a_data, a_sel, a_done, a_error}, 32'd0);
        chk("rst_count", 32'(a_count), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        chk("idle_ready", 32'(a_ready), 32'd0);

        // Single record 85/A5
        pulse_start();
        chk("t1_hdr_ready", 32'(a_ready), 32'd1);
        chk("t1_busy", 32'(a_busy), 32'd1);
        base = strobe_n;
        in_data = 8'h85; in_valid = 1'b1;
        tick();
        chk("t1_dat_ready", 32'(a_ready), 32'd1);
        chk("t1_addr_early", 32'(a_addr), 32'd0);
        in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        chk("t1_setup_addr", 32'(a_addr), 32'd5);
        chk("t1_setup_data", 32'(a_data), 32'hA5);
        chk("t1_setup_sel", 32'(a_sel), 32'd0);
        chk("t1_setup_ready", 32'(a_ready), 32'd0);
        tick();
        chk("t1_strobe_sel", 32'(a_sel), 32'd1);
        tick();
        chk("t1_hold_sel", 32'(a_sel), 32'd0);
        chk("t1_hold_addr", 32'(a_addr), 32'd5);
        chk("t1_hold_done", 32'(a_done), 32'd0);
        tick();
        chk("t1_done", 32'(a_done), 32'd1);
        chk("t1_busy_low", 32'(a_busy), 32'd0);
        chk("t1_count", 32'(a_count), 32'd1);
        chk("t1_fin_ready", 32'(a_ready), 32'd0);
        repeat (5) tick();
        chk("t1_strobes", 32'(strobe_n - base), 32'd1);

        // Three back-to-back records, IN_VALID held high
        pulse_start();
        chk("t2_count_clr", 32'(a_count), 32'd0);
        chk("t2_done_clr", 32'(a_done), 32'd0);
        base = strobe_n;
        send(8'h00, 1'b0); send(8'h11, 1'b0);
        send(8'h3F, 1'b0); send(8'h22, 1'b0);
        send(8'h8A, 1'b0); send(8'h33, 1'b0);
        in_valid = 1'b0;
        repeat (4) tick();
        chk("t2_strobes", 32'(strobe_n - base), 32'd3);
        chk("t2_gap1", 32'(strobe_at[(base + 1) % 16] - strobe_at[base % 16]), 32'd5);
        chk("t2_gap2", 32'(strobe_at[(base + 2) % 16] - strobe_at[(base + 1) % 16]), 32'd5);
        chk("t2_count", 32'(a_count), 32'd3);
        chk("t2_done", 32'(a_done), 32'd1);
        chk("t2_addr", 32'(a_addr), 32'h0A);
        chk("t2_data", 32'(a_data), 32'h33);

        // Stalled stream between header and data
        pulse_start();
        base = strobe_n;
        send(8'h07, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("t3_stall_ready", 32'(a_ready), 32'd1);
            chk("t3_stall_addr", 32'(a_addr), 32'h0A);
            tick();
        end
        chk("t3_stall_strobes", 32'(strobe_n - base), 32'd0);
        send(8'h5A, 1'b0);
        in_valid = 1'b0;
        chk("t3_addr", 32'(a_addr), 32'd7);
        chk("t3_data", 32'(a_data), 32'h5A);
        send(8'h81, 1'b0); send(8'h66, 1'b0);
        in_valid = 1'b0;
        repeat (4) tick();
        chk("t3_done", 32'(a_done), 32'd1);
        chk("t3_count", 32'(a_count), 32'd2);
        chk("t3_strobes", 32'(strobe_n - base), 32'd2);

        // Reserved bit set in header
        pulse_start();
        base = strobe_n;
        send(8'h41, 1'b0);
        chk("t4_error", 32'(a_error), 32'd1);
        chk("t4_ready", 32'(a_ready), 32'd0);
        chk("t4_busy", 32'(a_busy), 32'd0);
        repeat (3) tick();
        in_valid = 1'b0;
        chk("t4_strobes", 32'(strobe_n - base), 32'd0);
        chk("t4_count", 32'(a_count), 32'd0);
        pulse_start();
        chk("t4_err_clr", 32'(a_error), 32'd0);
        chk("t4_restart_ready", 32'(a_ready), 32'd1);

        // MAX_ADDRESS = 39 on instance b, HOLD_CYCLES = 3
        reset = 1'b1; tick(); reset = 1'b0;
        pulse_start();
        send(8'h28, 1'b1);
        in_valid = 1'b0;
        chk("t5_b_err", 32'(b_error), 32'd1);
        chk("t5_a_noerr", 32'(a_error), 32'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        pulse_start();
        send(8'hA7, 1'b1);
        chk("t5_b_accept", 32'(b_error), 32'd0);
        send(8'h3C, 1'b1);
        in_valid = 1'b0;
        chk("t5_b_addr", 32'(b_addr), 32'd39);
        chk("t5_b_data", 32'(b_data), 32'h3C);
        tick();
        chk("t5_b_strobe", 32'(b_sel), 32'd1);
        repeat (3) tick();
        chk("t5_b_hold_sel", 32'(b_sel), 32'd0);
        chk("t5_b_hold_busy", 32'(b_busy), 32'd1);
        chk("t5_b_hold_addr", 32'(b_addr), 32'd39);
        tick();
        chk("t5_b_done", 32'(b_done), 32'd1);
        chk("t5_b_count", 32'(b_count), 32'd1);

        // Reset during STROBE, then a clean session
        pulse_start();
        send(8'h83, 1'b0); send(8'h44, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("t6_strobe", 32'(a_sel), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_sel", 32'(a_sel), 32'd0);
        chk("t6_outs", {a_addr, a_data, a_ready, a_busy, a_done, a_error}, 32'd0);
        chk("t6_count", 32'(a_count), 32'd0);
        base = strobe_n;
        pulse_start();
        send(8'h82, 1'b0); send(8'h99, 1'b0);
        in_valid = 1'b0;
        repeat (3) tick();
        chk("t6_done", 32'(a_done), 32'd1);
        chk("t6_count2", 32'(a_count), 32'd1);
        chk("t6_addr", 32'(a_addr), 32'd2);
        chk("t6_data", 32'(a_data), 32'h99);
        chk("t6_strobes", 32'(strobe_n - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
